adc_sample_packer: RTL and testbench

ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

---
 rtl/adc_packer_pkg.sv | 12 +
 rtl/adc_frame_buf.sv | 50 +++++
 rtl/adc_sample_packer.sv | 82 ++++++++
 tb/tb_adc_sample_packer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_packer_pkg.sv
// adc_packer_pkg: shared sizes, output FSM states and channel-scan helper for adc_sample_packer
package adc_packer_pkg;
  localparam int NUM_CH = 16;
  localparam int SAMPLE_W = 12;
  localparam int CH_IDX_W = 4;
  localparam int FRAME_W = NUM_CH * SAMPLE_W;
  typedef enum logic {IDLE, SEND} state_e;
  function automatic logic [CH_IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (m[i]) lowest_set = CH_IDX_W'(i);
  endfunction
endpackage

// File: rtl/adc_frame_buf.sv
// adc_frame_buf: 2-entry snapshot FIFO of captured frames (samples + effective mask)
module adc_frame_buf import adc_packer_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] wr_data,
  input  logic [NUM_CH-1:0]  wr_mask,
  output logic [FRAME_W-1:0] rd_data,
  output logic [NUM_CH-1:0]  rd_mask,
  output logic [1:0]         count,
  output logic [1:0]         count_nxt
);
  logic [FRAME_W-1:0] data_q [2];
  logic [FRAME_W-1:0] data_d [2];
  logic [NUM_CH-1:0]  mask_q [2];
  logic [NUM_CH-1:0]  mask_d [2];
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (push) begin
      data_d[wr_ptr_q] = wr_data;
      mask_d[wr_ptr_q] = wr_mask;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    mask_q <= mask_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign rd_data = data_q[rd_ptr_q];
  assign rd_mask = mask_q[rd_ptr_q];
  assign count = count_q;
  assign count_nxt = count_d;
endmodule

// File: rtl/adc_sample_packer.sv
// adc_sample_packer: captures 16-channel ADC frames and streams enabled channels as {idx, sample} beats
// Optional zero suppression of in-band samples is enabled by defining ADC_PACKER_ZS_EN.
module adc_sample_packer import adc_packer_pkg::*; #(
  parameter logic [SAMPLE_W-1:0] SIGNAL_LEVEL1 = 12'h7B7,
  parameter logic [SAMPLE_W-1:0] SIGNAL_LEVEL2 = 12'h81B,
  parameter int                  OVF_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic               des_run,
  input  logic [FRAME_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]  ch_mask,
  output logic [15:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic [OVF_W-1:0]   ovf_cnt
);
  if (SIGNAL_LEVEL1 > SIGNAL_LEVEL2) begin : g_band_check
    $error("SIGNAL_LEVEL1 must not exceed SIGNAL_LEVEL2");
  end
  logic [NUM_CH-1:0] eff_mask;
`ifdef ADC_PACKER_ZS_EN
  logic [NUM_CH-1:0] in_band;
  always_comb begin
    for (int k = 0; k < NUM_CH; k++)
      in_band[k] = ch_data[k*SAMPLE_W +: SAMPLE_W] >= SIGNAL_LEVEL1 && ch_data[k*SAMPLE_W +: SAMPLE_W] <= SIGNAL_LEVEL2;
    eff_mask = ch_mask & ~in_band;
  end
`else
  assign eff_mask = ch_mask;
`endif
  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  sent_q, sent_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;
  logic               cap_req, push, drop, pop, hs, last;
  logic [1:0]         count, count_nxt;
  logic [FRAME_W-1:0] head_data;
  logic [NUM_CH-1:0]  head_mask, rem, cur_bit;
  logic [CH_IDX_W-1:0] cur;
  logic [7:0]         base;
  adc_frame_buf u_buf (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .wr_data(ch_data), .wr_mask(eff_mask),
    .rd_data(head_data), .rd_mask(head_mask),
    .count(count), .count_nxt(count_nxt)
  );
  // A full buffer drops the capture even if the head frame completes this cycle.
  always_comb begin
    cap_req = sample_en && !des_run && |eff_mask;
    push = cap_req && count != 2'd2;
    drop = cap_req && count == 2'd2;
    rem = head_mask & ~sent_q;
    cur = lowest_set(rem);
    cur_bit = NUM_CH'(1) << cur;
    last = (rem & ~cur_bit) == '0;
    out_valid = state_q == SEND;
    hs = out_valid && out_ready;
    pop = hs && last;
    base = 8'(cur) * 8'(SAMPLE_W);
    out_data = out_valid ? {cur, head_data[base +: SAMPLE_W]} : '0;
    out_last = out_valid && last;
    busy = count != 2'd0;
    state_d = state_q == IDLE ? (busy ? SEND : IDLE) : (pop && count_nxt == 2'd0 ? IDLE : SEND);
    sent_d = hs ? (last ? '0 : sent_q | cur_bit) : sent_q;
    ovf_d = drop && !(&ovf_q) ? ovf_q + 1'b1 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sent_q <= '0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      sent_q <= sent_d;
      ovf_q <= ovf_d;
    end
  end
  assign ovf_cnt = ovf_q;
endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: table-driven frame vectors plus directed back-pressure, overflow, reset and ZS sequences
module tb_adc_sample_packer;
  logic         clk, rst, sample_en, des_run, out_valid, out_ready, out_last, busy;
  logic [191:0] ch_data;
  logic [15:0]  ch_mask, out_data;
  logic [7:0]   ovf_cnt;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] beats[$];
  int bcyc[$];
  int nlast, lidx;

  adc_sample_packer dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .des_run(des_run),
    .ch_data(ch_data), .ch_mask(ch_mask), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .ovf_cnt(ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    int          n;
    logic [15:0] first;
    logic [15:0] lastb;
  } vec_t;
  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic collect(input int cycles);
    beats.delete();
    bcyc.delete();
    nlast = 0;
    lidx = -1;
    for (int c = 0; c < cycles; c++) begin
      if (out_valid && out_ready) begin
        beats.push_back(out_data);
        bcyc.push_back(c);
        if (out_last) begin
          nlast++;
          lidx = beats.size() - 1;
        end
      end
      tick();
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [191:0] pat;
    logic [7:0] ovf_before;
    int j;
    rst = 1'b1; sample_en = 1'b0; des_run = 1'b0; ch_data = '0; ch_mask = '0; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) pat[k*12 +: 12] = {4'(k), 8'hA5};
    vecs[0] = '{16'h0001, 1, 16'h00A5, 16'h00A5};
    vecs[1] = '{16'h8000, 1, 16'hFFA5, 16'hFFA5};
    vecs[2] = '{16'h0005, 2, 16'h00A5, 16'h22A5};
    vecs[3] = '{16'hFFFF, 16, 16'h00A5, 16'hFFA5};
    vecs[4] = '{16'h0180, 2, 16'h77A5, 16'h88A5};
    vecs[5] = '{16'h0000, 0, 16'h0000, 16'h0000};
    vecs[6] = '{16'hA000, 2, 16'hDDA5, 16'hFFA5};
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf_cnt, 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      out_ready = 1'b1; ch_mask = vecs[v].mask; ch_data = pat; sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
      chk("lat0_valid", out_valid, 0);
      chk("cap_busy", busy, vecs[v].n > 0);
      tick();
      chk("lat1_valid", out_valid, vecs[v].n > 0);
      collect(24);
      chk("nbeats", beats.size(), vecs[v].n);
      chk("nlast", nlast, vecs[v].n > 0 ? 1 : 0);
      if (vecs[v].n > 0) begin
        chk("first_beat", beats[0], vecs[v].first);
        chk("last_beat", beats[beats.size()-1], vecs[v].lastb);
        chk("last_pos", lidx, vecs[v].n - 1);
      end
      j = 0;
      for (int k = 0; k < 16; k++)
        if (vecs[v].mask[k]) begin
          if (j < beats.size()) chk("beat_model", beats[j], {4'(k), 4'(k), 8'hA5});
          j++;
        end
      chk("idle_busy", busy, 0);
    end

    out_ready = 1'b0; ch_data = '0; ch_data[11:0] = 12'h123; ch_data[35:24] = 12'hABC; ch_mask = 16'h0005;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", out_data, 16'h0123);
      chk("hold_valid", out_valid, 1);
      chk("hold_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    chk("beat0", out_data, 16'h0123);
    tick();
    chk("beat1", out_data, 16'h2ABC);
    chk("beat1_last", out_last, 1);
    tick();
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 0);

    out_ready = 1'b0; ch_data = pat; ch_mask = 16'hFFFF; sample_en = 1'b1;
    repeat (3) tick();
    sample_en = 1'b0;
    chk("ovf_cnt1", ovf_cnt, 1);
    chk("ovf_busy", busy, 1);
    chk("ovf_valid", out_valid, 1);
    out_ready = 1'b1;
    collect(40);
    chk("ovf_nbeats", beats.size(), 32);
    chk("ovf_nlast", nlast, 2);
    if (beats.size() == 32) begin
      chk("ovf_nogap", bcyc[31] - bcyc[0], 31);
      chk("ovf_f2_first", beats[16], 16'h00A5);
      chk("ovf_f1_last", beats[15], 16'hFFA5);
    end
    chk("ovf_keep", ovf_cnt, 1);
    do_reset();

    out_ready = 1'b0; ch_mask = 16'h0001; sample_en = 1'b1;
    repeat (2) tick();
    sample_en = 1'b0;
    tick();
    out_ready = 1'b1; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("pop_nofree_ovf", ovf_cnt, 1);
    chk("pop_next_valid", out_valid, 1);
    collect(6);
    chk("pop_nofree_beats", beats.size(), 1);
    do_reset();

    out_ready = 1'b0; ch_mask = 16'h0001; sample_en = 1'b1;
    repeat (300) tick();
    sample_en = 1'b0;
    chk("ovf_sat", ovf_cnt, 8'hFF);
    rst = 1'b1; sample_en = 1'b1;
    tick();
    rst = 1'b0; sample_en = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", ovf_cnt, 0);
    tick();
    chk("postrst_valid", out_valid, 0);
    chk("postrst_busy", busy, 0);

    out_ready = 1'b1; des_run = 1'b1; ch_mask = 16'hFFFF; sample_en = 1'b1;
    repeat (3) tick();
    sample_en = 1'b0; des_run = 1'b0;
    tick();
    chk("desrun_valid", out_valid, 0);
    chk("desrun_busy", busy, 0);
    chk("desrun_ovf", ovf_cnt, 0);

    ch_data = '0; ch_data[11:0] = 12'h7D0; ch_data[23:12] = 12'h900; ch_mask = 16'h0003; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    collect(6);
`ifdef ADC_PACKER_ZS_EN
    chk("zs_nbeats", beats.size(), 1);
    if (beats.size() > 0) chk("zs_beat", beats[0], 16'h1900);
    chk("zs_nlast", nlast, 1);
`else
    chk("nozs_nbeats", beats.size(), 2);
    if (beats.size() > 1) begin
      chk("nozs_beat0", beats[0], 16'h07D0);
      chk("nozs_beat1", beats[1], 16'h1900);
    end
`endif
    ovf_before = ovf_cnt;
    ch_data[11:0] = 12'h7B7; ch_data[23:12] = 12'h81B; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
`ifdef ADC_PACKER_ZS_EN
    chk("zs_band_busy", busy, 0);
`else
    chk("nozs_band_busy", busy, 1);
`endif
    tick();
    collect(6);
    chk("band_ovf", ovf_cnt, ovf_before);
`ifdef ADC_PACKER_ZS_EN
    chk("zs_band_beats", beats.size(), 0);
`else
    chk("nozs_band_beats", beats.size(), 2);
    if (beats.size() > 1) begin
      chk("nozs_band0", beats[0], 16'h07B7);
      chk("nozs_band1", beats[1], 16'h181B);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
